lsmitll_kofn_t: RTL and testbench

- Parametrised successor of the clocked two-input AND cell: N pulse inputs, one clock, one pulse output.
- On each clock pulse, q emits a pulse if at least THRESHOLD distinct inputs pulsed since the previous clock pulse, then the cell clears.
- THRESHOLD=N gives an N-input clocked AND; THRESHOLD=1 gives a clocked OR. Intermediate values give a majority or k-of-N gate.
- Behavioural timing model for RSFQ netlist simulation. Adds a synchronous reset, hold-window checking and duplicate-pulse detection.

---
 rtl/lsmitll_kofn_t_pkg.sv | 18 +
 rtl/lsmitll_pulse_arm.sv | 44 ++++
 rtl/lsmitll_kofn_t.sv | 125 ++++++++++++
 tb/tb_lsmitll_kofn_t.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lsmitll_kofn_t_pkg.sv
// lsmitll_kofn_t_pkg
// Shared defaults for the clocked k-of-N pulse gate family. All timing values
// are in sampling ticks of i_clk; one tick stands for 100 fs, so 9.3 ps -> 93.
// No ports (package).
package lsmitll_kofn_t_pkg;

  localparam int TICK_FS       = 100;
  localparam int BEGIN_TIME_T  = 80;  // 8.0 ps: cell leaves its unknown state
  localparam int DELAY_CLK_Q_T = 93;  // 9.3 ps: clk pulse -> q pulse
  localparam int CT_HOLD_T     = 38;  // 3.8 ps: hold window after a clk pulse
  localparam int DELAY_ERR_T   = 20;  // 2.0 ps: offending pulse -> err/viol

  // Width able to hold a value 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsmitll_pulse_arm.sv
// lsmitll_pulse_arm
// One data input of the k-of-N gate: turns toggles on a din bit into a sticky
// armed flag that a clear strobe drops.
// Ports:
//   i_clk   sampling clock
//   i_rst   synchronous active-high reset (time-zero event)
//   i_en    cell is past its begin time; toggles before that are ignored
//   i_din   data line, every transition is one pulse
//   i_clr   clear strobe from the clk evaluation
//   o_pls   a pulse was seen on this tick
//   o_hit   flag as the closing evaluation sees it (armed or arriving now)
//   o_dup   pulse arrived while already armed
module lsmitll_pulse_arm (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_clr,
  output logic o_pls,
  output logic o_hit,
  output logic o_dup
);

  logic r_din_d;
  logic r_armed;

  assign o_pls = (i_din ^ r_din_d) & i_en;
  assign o_hit = r_armed | o_pls;
  assign o_dup = r_armed & o_pls;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Track the line level so the first edge after reset is not a pulse.
      r_din_d <= i_din;
      r_armed <= 1'b0;
    end else begin
      r_din_d <= i_din;
      // A pulse coincident with the clear was already counted via o_hit.
      if (i_clr)      r_armed <= 1'b0;
      else if (o_pls) r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/lsmitll_kofn_t.sv
// lsmitll_kofn_t
// Clocked k-of-N pulse gate, tick-sampled model. On each clk pulse q pulses if
// at least THRESHOLD distinct inputs pulsed since the previous clk pulse; the
// armed flags then clear. Pulses are transitions on the lines.
// Ports:
//   i_clk      sampling clock (time base, one tick per edge)
//   i_rst      synchronous active-high reset; its release is time zero
//   i_clk_pls  gate clock pulse line (any transition)
//   i_rst_lvl  gate reset level, only looked at on a clk pulse
//   i_din      N data pulse lines
//   o_q        result pulse, DELAY_CLK_Q ticks after a firing clk pulse
//   o_err      pulse per duplicate data pulse, DELAY_ERR ticks later
//   o_viol     pulse per hold violation, DELAY_ERR ticks later
import lsmitll_kofn_t_pkg::*;

module lsmitll_kofn_t #(
  parameter int N           = 2,
  parameter int THRESHOLD   = N,
  parameter int BEGIN_TIME  = BEGIN_TIME_T,
  parameter int DELAY_CLK_Q = DELAY_CLK_Q_T,
  parameter int CT_HOLD     = CT_HOLD_T,
  parameter int DELAY_ERR   = DELAY_ERR_T
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_pls,
  input  logic         i_rst_lvl,
  input  logic [N-1:0] i_din,
  output logic         o_q,
  output logic         o_err,
  output logic         o_viol
);

  localparam int CW = cnt_w(N);
  localparam int BW = cnt_w(BEGIN_TIME);
  localparam int HW = cnt_w(CT_HOLD);

  if (N < 2 || N > 16 || THRESHOLD < 1 || THRESHOLD > N ||
      DELAY_CLK_Q < 2 || DELAY_ERR < 2 || CT_HOLD < 1 || BEGIN_TIME < 1) begin : g_param_err
    $fatal(1, "lsmitll_kofn_t: parameter out of range");
  end

  logic [BW-1:0]          r_begin_cnt;
  logic                   r_clk_d;
  logic [HW-1:0]          r_hold;
  logic [DELAY_CLK_Q-1:0] r_q_sr;
  logic [DELAY_ERR-1:0]   r_err_sr;
  logic [DELAY_ERR-1:0]   r_viol_sr;
  logic                   r_q;
  logic                   r_err;
  logic                   r_viol;

  logic          w_live;
  logic          w_clk_evt;
  logic          w_in_hold;
  logic [N-1:0]  w_pls;
  logic [N-1:0]  w_hit;
  logic [N-1:0]  w_dup;
  logic [CW-1:0] w_cnt;
  logic          w_fire;
  logic          w_err_evt;
  logic          w_viol_evt;

  assign w_live    = (r_begin_cnt == '0);
  assign w_clk_evt = (i_clk_pls ^ r_clk_d) & w_live;
  assign w_in_hold = (r_hold != '0);

  for (genvar gi = 0; gi < N; gi++) begin : g_arm
    lsmitll_pulse_arm u_arm (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_live),
      .i_din (i_din[gi]),
      .i_clr (w_clk_evt),
      .o_pls (w_pls[gi]),
      .o_hit (w_hit[gi]),
      .o_dup (w_dup[gi])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) w_cnt = w_cnt + CW'(w_hit[i]);
  end

  assign w_fire = w_clk_evt & ~i_rst_lvl & (w_cnt >= CW'(THRESHOLD));

  // Several events on one tick land at the same instant; only their parity
  // is visible on a toggle-encoded output.
  assign w_err_evt  = ^w_dup;
  assign w_viol_evt = (^w_pls) & w_in_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_begin_cnt <= BW'(BEGIN_TIME);
      r_clk_d     <= i_clk_pls;
      r_hold      <= '0;
      r_q_sr      <= '0;
      r_err_sr    <= '0;
      r_viol_sr   <= '0;
      r_q         <= 1'b0;
      r_err       <= 1'b0;
      r_viol      <= 1'b0;
    end else begin
      if (!w_live) r_begin_cnt <= r_begin_cnt - 1'b1;
      r_clk_d <= i_clk_pls;
      // Down-counter: nonzero on the next CT_HOLD-1 ticks after a clk pulse,
      // so a data pulse exactly CT_HOLD ticks later is clean.
      if (w_clk_evt)      r_hold <= HW'(CT_HOLD - 1);
      else if (w_in_hold) r_hold <= r_hold - 1'b1;
      // Delay lines keep every event, so closely spaced fires stay ordered.
      r_q_sr    <= {r_q_sr[DELAY_CLK_Q-2:0], w_fire};
      r_err_sr  <= {r_err_sr[DELAY_ERR-2:0], w_err_evt};
      r_viol_sr <= {r_viol_sr[DELAY_ERR-2:0], w_viol_evt};
      r_q       <= r_q    ^ r_q_sr[DELAY_CLK_Q-1];
      r_err     <= r_err  ^ r_err_sr[DELAY_ERR-1];
      r_viol    <= r_viol ^ r_viol_sr[DELAY_ERR-1];
    end
  end

  assign o_q    = r_q;
  assign o_err  = r_err;
  assign o_viol = r_viol;

endmodule

// File: tb/tb_lsmitll_kofn_t.sv
// tb_lsmitll_kofn_t
// Five gate configurations run side by side on one time base (1 tick = 0.1 ps).
// An event-time model schedules output toggles and is compared every tick;
// a table of literal expectations pins the model to hand-worked times.
module tb_lsmitll_kofn_t;

  localparam int NC = 5;
  localparam int NS [NC] = '{4, 4, 2, 2, 3};
  localparam int TS [NC] = '{4, 3, 2, 1, 3};
  localparam int T_BEGIN = 80;
  localparam int T_CQ    = 93;
  localparam int T_HOLD  = 38;
  localparam int T_ERR   = 20;
  localparam int T_END   = 1200;

  typedef struct { int t; int c; int kind; int idx; } ev_t;   // kind 0 din, 1 clk, 2 rst level
  typedef struct { int t; int c; int sig; bit v; } lit_t;     // sig 0 q, 1 err, 2 viol
  typedef struct { int t; int c; int sig; } sched_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0][3:0] din;
  logic [NC-1:0] clkp;
  logic [NC-1:0] rstl;
  logic [NC-1:0] q_o;
  logic [NC-1:0] err_o;
  logic [NC-1:0] viol_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    lsmitll_kofn_t #(.N(NS[g]), .THRESHOLD(TS[g])) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clk_pls (clkp[g]),
      .i_rst_lvl (rstl[g]),
      .i_din     (din[g][NS[g]-1:0]),
      .o_q       (q_o[g]),
      .o_err     (err_o[g]),
      .o_viol    (viol_o[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  ev_t    evs[$];
  lit_t   lits[$];
  sched_t sched[$];

  // ---------------- behavioural model ----------------
  bit [3:0] m_armed [NC];
  bit [3:0] m_prev  [NC];
  bit       m_pclk  [NC];
  int       m_last_clk [NC];
  bit [2:0] m_exp   [NC];   // {viol, err, q}
  int  e_cnt   = 0;
  int  m_last_e = -1;
  bit  m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_armed[c] = '0; m_prev[c] = din[c]; m_pclk[c] = clkp[c];
        m_last_clk[c] = -100000; m_exp[c] = '0;
      end
      sched.delete();
      e_cnt = 0; m_valid = 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit [3:0] pls;
        bit       cp;
        pls = (din[c] ^ m_prev[c]) & 4'((1 << NS[c]) - 1);
        cp  = clkp[c] ^ m_pclk[c];
        m_prev[c] = din[c];
        m_pclk[c] = clkp[c];
        if (e_cnt >= T_BEGIN) begin
          for (int i = 0; i < NS[c]; i++) begin
            if (pls[i]) begin
              if (e_cnt - m_last_clk[c] < T_HOLD) sched.push_back('{e_cnt + T_ERR, c, 2});
              if (m_armed[c][i]) sched.push_back('{e_cnt + T_ERR, c, 1});
              m_armed[c][i] = 1'b1;
            end
          end
          if (cp) begin
            if (!rstl[c] && $countones(m_armed[c]) >= TS[c]) sched.push_back('{e_cnt + T_CQ, c, 0});
            m_armed[c] = '0;
            m_last_clk[c] = e_cnt;
          end
        end
      end
      for (int j = sched.size() - 1; j >= 0; j--) begin
        if (sched[j].t == e_cnt) begin
          m_exp[sched[j].c][sched[j].sig] = ~m_exp[sched[j].c][sched[j].sig];
          sched.delete(j);
        end
      end
      m_last_e = e_cnt;
      m_valid = 1;
      e_cnt++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      for (int c = 0; c < NC; c++) begin
        bit [2:0] act;
        act = {viol_o[c], err_o[c], q_o[c]};
        for (int s = 0; s < 3; s++) begin
          n_tests++;
          if (act[s] !== m_exp[c][s]) begin
            n_fail++;
            if (n_fail <= 30)
              $display("FAIL model cfg%0d sig%0d tick %0d: got %b want %b", c, s, m_last_e, act[s], m_exp[c][s]);
          end
        end
      end
      foreach (lits[k]) begin
        if (lits[k].t == m_last_e) begin
          bit a;
          a = (lits[k].sig == 0) ? q_o[lits[k].c] : (lits[k].sig == 1) ? err_o[lits[k].c] : viol_o[lits[k].c];
          n_tests++;
          if (a !== lits[k].v) begin
            n_fail++;
            $display("FAIL literal cfg%0d sig%0d tick %0d: got %b want %b", lits[k].c, lits[k].sig, lits[k].t, a, lits[k].v);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic void ev(int t, int c, int kind, int idx);
    evs.push_back('{t, c, kind, idx});
  endfunction
  function automatic void lit(int t, int c, int sig, bit v);
    lits.push_back('{t, c, sig, v});
  endfunction

  initial begin
    din = '0; clkp = '0; rstl = '0;
    // cfg0: 4-input AND; back-to-back clks afterwards do nothing
    ev(200,0,0,0); ev(220,0,0,1); ev(240,0,0,2); ev(260,0,0,3);
    ev(400,0,1,0); ev(800,0,1,0); ev(850,0,1,0);
    // cfg1: 3-of-4; then two fires closer together than the clk->q delay
    ev(200,1,0,1); ev(200,1,0,3); ev(400,1,1,0);
    ev(500,1,0,0); ev(500,1,0,1); ev(500,1,0,2); ev(700,1,1,0);
    ev(950,1,0,0); ev(950,1,0,1); ev(950,1,0,2); ev(1000,1,1,0);
    ev(1045,1,0,0); ev(1045,1,0,1); ev(1045,1,0,2); ev(1050,1,1,0);
    // cfg2: pre-begin pulses, duplicate, then data coincident with clk
    ev(30,2,0,0); ev(30,2,1,0);
    ev(200,2,0,0); ev(250,2,0,0); ev(300,2,0,1); ev(400,2,1,0);
    ev(600,2,0,0); ev(800,2,0,1); ev(800,2,1,0);
    // cfg3: clocked OR with gate reset level
    ev(100,3,2,1); ev(200,3,0,0); ev(400,3,1,0); ev(500,3,2,0);
    ev(600,3,1,0); ev(700,3,0,1); ev(900,3,1,0);
    // cfg4: hold violation, held-over flag, hold-window boundary
    ev(400,4,1,0); ev(420,4,0,2); ev(500,4,0,0); ev(500,4,0,1); ev(700,4,1,0);
    ev(737,4,0,0); ev(738,4,0,1);

    lit(492,0,0,0); lit(493,0,0,1); lit(1000,0,0,1);
    lit(600,1,0,0); lit(792,1,0,0); lit(793,1,0,1); lit(1092,1,0,1);
    lit(1093,1,0,0); lit(1142,1,0,0); lit(1143,1,0,1);
    lit(240,2,1,0); lit(269,2,1,0); lit(270,2,1,1); lit(493,2,0,1);
    lit(892,2,0,1); lit(893,2,0,0); lit(900,2,2,0);
    lit(500,3,0,0); lit(800,3,0,0); lit(992,3,0,0); lit(993,3,0,1);
    lit(439,4,2,0); lit(440,4,2,1); lit(756,4,2,1); lit(757,4,2,0);
    lit(760,4,2,0); lit(793,4,0,1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= T_END; k++) begin
      foreach (evs[j]) begin
        if (evs[j].t == k) begin
          case (evs[j].kind)
            0: din[evs[j].c][evs[j].idx] = ~din[evs[j].c][evs[j].idx];
            1: clkp[evs[j].c] = ~clkp[evs[j].c];
            default: rstl[evs[j].c] = (evs[j].idx != 0);
          endcase
        end
      end
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
